serial_subtractor: RTL and testbench

// - Multi-cycle bit-serial subtractor: D = X - Y - B0. It is the inverse companion
//   of the 8-bit adder datapath: given a sum and one addend, it recovers the other.
// - Handles BITS_PER_CYCLE bits per clock through a ripple-borrow full-subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/serial_subtractor_fullsubtractor.sv | 14 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the serial subtractor.
// Common to the adder datapath through SERSUB_WIDTH.
package serial_subtractor_pkg;

  localparam int SERSUB_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand bus of the serial subtractor.
// OVF exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SERSUB_WIDTH
);

  logic             START;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             B0;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             BUSY;
  logic             DONE;
`ifdef SERSUB_OVF_EN
  logic             OVF;
`endif

  modport master (
    output START, X, Y, B0,
`ifdef SERSUB_OVF_EN
    input  OVF,
`endif
    input  D, BOUT, BUSY, DONE
  );

  modport slave (
    input  START, X, Y, B0,
`ifdef SERSUB_OVF_EN
    output OVF,
`endif
    output D, BOUT, BUSY, DONE
  );

endinterface

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full-subtractor slice: d = a - b - bin.
// Purely combinational; chained by the top for multi-bit steps.
module fullsubtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = X - Y - B0, BITS_PER_CYCLE bits per clock.
// Define SERSUB_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH          = SERSUB_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / B;
  localparam int CW    = cnt_bits(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;

  logic [B-1:0]     sd;
  logic [B:0]       bw;

  assign bw[0] = brw_q;

  for (genvar g = 0; g < B; g++) begin : g_slice
    fullsubtractor u_fs (
      .d    (sd[g]),
      .bout (bw[g+1]),
      .a    (x_q[g]),
      .b    (y_q[g]),
      .bin  (bw[g])
    );
  end

`ifdef SERSUB_OVF_EN
  // Operand MSBs are kept because the shift registers lose them
  logic xm_q, xm_d;
  logic ym_q, ym_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef SERSUB_OVF_EN
    xm_d    = xm_q;
    ym_d    = ym_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.START) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          x_d     = bus.X;
          y_d     = bus.Y;
          brw_d   = bus.B0;
`ifdef SERSUB_OVF_EN
          xm_d    = bus.X[WIDTH-1];
          ym_d    = bus.Y[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        x_d   = x_q >> B;
        y_d   = y_q >> B;
        d_d   = {sd, d_q[WIDTH-1:B]};
        brw_d = bw[B];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          bout_d  = bw[B];
`ifdef SERSUB_OVF_EN
          ovf_d   = (xm_q ^ ym_q) & (sd[B-1] ^ xm_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERSUB_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xm_q  <= 1'b0;
      ym_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      xm_q  <= xm_d;
      ym_q  <= ym_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.OVF = ovf_q;
`endif

  assign bus.D    = d_q;
  assign bus.BOUT = bout_q;
  assign bus.BUSY = (state_q == S_SHIFT);
  assign bus.DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at 1, 2 and 4 bits/cycle.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) sif1 ();
  serial_subtractor_if #(.WIDTH(8)) sif2 ();
  serial_subtractor_if #(.WIDTH(8)) sif4 ();

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (sif1)
  );
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (sif2)
  );
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (sif4)
  );

  // Drive op on dut1; returns cycles from START edge to DONE
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input logic b, output logic [7:0] d,
                        output logic bo, output logic ov,
                        output int lat);
    int k;
    @(negedge clk);
    sif1.X = x; sif1.Y = y; sif1.B0 = b; sif1.START = 1'b1;
    @(negedge clk);
    sif1.START = 1'b0;
    k = 1;
    while (!sif1.DONE && k < 20) begin
      @(negedge clk);
      k++;
    end
    lat = sif1.DONE ? k - 1 : -1;
    d   = sif1.D;
    bo  = sif1.BOUT;
`ifdef SERSUB_OVF_EN
    ov  = sif1.OVF;
`else
    ov  = 1'b0;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({sif1.D, sif1.BOUT, sif1.BUSY, sif1.DONE} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got D=%h BOUT=%b BUSY=%b DONE=%b want 0",
               sif1.D, sif1.BOUT, sif1.BUSY, sif1.DONE);
    end
`ifdef SERSUB_OVF_EN
    n_cmp++;
    if (sif1.OVF !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b want 0", sif1.OVF);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo, ov; int lat;
    run_op(8'h05, 8'h03, 1'b0, d, bo, ov, lat);
    n_cmp++;
    if ({bo, d} !== 9'h002) begin
      n_bad++;
      $display("FAIL basic_05_03: got BOUT=%b D=%h want 0/02", bo, d);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    @(negedge clk);
    n_cmp++;
    if ({sif1.DONE, sif1.BUSY, sif1.D} !== 10'h002) begin
      n_bad++;
      $display("FAIL done_pulse_hold: got DONE=%b BUSY=%b D=%h want 0/0/02",
               sif1.DONE, sif1.BUSY, sif1.D);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] d; logic bo, ov; int lat;
    run_op(8'h00, 8'h01, 1'b0, d, bo, ov, lat);
    n_cmp++;
    if ({bo, d} !== 9'h1FF || lat !== 8) begin
      n_bad++;
      $display("FAIL sub_00_01: got BOUT=%b D=%h lat=%0d want 1/FF/8",
               bo, d, lat);
    end
`ifdef SERSUB_OVF_EN
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_00_01: got %b want 0", ov);
    end
`endif
    run_op(8'h80, 8'h01, 1'b0, d, bo, ov, lat);
    n_cmp++;
    if ({bo, d} !== 9'h07F) begin
      n_bad++;
      $display("FAIL sub_80_01: got BOUT=%b D=%h want 0/7F", bo, d);
    end
`ifdef SERSUB_OVF_EN
    n_cmp++;
    if (ov !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_80_01: got %b want 1", ov);
    end
`endif
    run_op(8'h10, 8'h0F, 1'b1, d, bo, ov, lat);
    n_cmp++;
    if ({bo, d} !== 9'h000) begin
      n_bad++;
      $display("FAIL sub_10_0F_b1: got BOUT=%b D=%h want 0/00", bo, d);
    end
  endtask

  task automatic test_midshift_start();
    int k;
    @(negedge clk);
    sif1.X = 8'h05; sif1.Y = 8'h03; sif1.B0 = 1'b0; sif1.START = 1'b1;
    @(negedge clk);
    sif1.START = 1'b0;
    repeat (2) @(negedge clk);
    sif1.X = 8'hFF; sif1.Y = 8'h00; sif1.B0 = 1'b1; sif1.START = 1'b1;
    @(negedge clk);
    sif1.START = 1'b0;
    n_cmp++;
    if (sif1.BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL midshift_busy: got %b want 1", sif1.BUSY);
    end
    k = 4;
    while (!sif1.DONE && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!sif1.DONE || k - 1 != 8 || {sif1.BOUT, sif1.D} !== 9'h002) begin
      n_bad++;
      $display("FAIL midshift_result: got DONE=%b lat=%0d BOUT=%b D=%h want 1/8/0/02",
               sif1.DONE, k - 1, sif1.BOUT, sif1.D);
    end
    @(negedge clk);
    n_cmp++;
    if (sif1.BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL midshift_not_queued: BUSY got %b want 0", sif1.BUSY);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    sif1.X = 8'h05; sif1.Y = 8'h03; sif1.B0 = 1'b0; sif1.START = 1'b1;
    @(negedge clk);
    sif1.START = 1'b0;
    k = 1;
    while (!sif1.DONE && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!sif1.DONE || sif1.D !== 8'h02) begin
      n_bad++;
      $display("FAIL b2b_first: got DONE=%b D=%h want 1/02", sif1.DONE, sif1.D);
    end
    sif1.X = 8'hAA; sif1.Y = 8'h55; sif1.START = 1'b1;
    @(negedge clk);
    sif1.START = 1'b0;
    n_cmp++;
    if ({sif1.BUSY, sif1.DONE} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_no_gap: got BUSY=%b DONE=%b want 1/0",
               sif1.BUSY, sif1.DONE);
    end
    k = 1;
    while (!sif1.DONE && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!sif1.DONE || k - 1 != 8 || {sif1.BOUT, sif1.D} !== 9'h055) begin
      n_bad++;
      $display("FAIL b2b_second: got lat=%0d BOUT=%b D=%h want 8/0/55",
               k - 1, sif1.BOUT, sif1.D);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midshift();
    logic [7:0] d; logic bo, ov; int lat;
    @(negedge clk);
    sif1.X = 8'h12; sif1.Y = 8'h34; sif1.B0 = 1'b1; sif1.START = 1'b1;
    @(negedge clk);
    sif1.START = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({sif1.D, sif1.BOUT, sif1.BUSY, sif1.DONE} !== 11'd0) begin
      n_bad++;
      $display("FAIL async_reset: got D=%h BOUT=%b BUSY=%b DONE=%b want 0",
               sif1.D, sif1.BOUT, sif1.BUSY, sif1.DONE);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'hAA, 8'h55, 1'b0, d, bo, ov, lat);
    n_cmp++;
    if ({bo, d} !== 9'h055 || lat !== 8) begin
      n_bad++;
      $display("FAIL after_reset_AA_55: got BOUT=%b D=%h lat=%0d want 0/55/8",
               bo, d, lat);
    end
  endtask

  task automatic test_random_sweep();
    logic [7:0] x, y, rd[3];
    logic       b, rb[3];
    logic [8:0] ex;
    int         rk[3];
    int         want[3];
    want[0] = 8; want[1] = 4; want[2] = 2;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      b = 1'($urandom);
      ex = {1'b0, x} - {1'b0, y} - {8'd0, b};
      @(negedge clk);
      sif1.X = x; sif1.Y = y; sif1.B0 = b; sif1.START = 1'b1;
      sif2.X = x; sif2.Y = y; sif2.B0 = b; sif2.START = 1'b1;
      sif4.X = x; sif4.Y = y; sif4.B0 = b; sif4.START = 1'b1;
      for (int j = 0; j < 3; j++) rk[j] = -1;
      @(negedge clk);
      sif1.START = 1'b0; sif2.START = 1'b0; sif4.START = 1'b0;
      for (int k = 1; k <= 11; k++) begin
        if (sif1.DONE && rk[0] < 0) begin
          rk[0] = k - 1; rd[0] = sif1.D; rb[0] = sif1.BOUT;
        end
        if (sif2.DONE && rk[1] < 0) begin
          rk[1] = k - 1; rd[1] = sif2.D; rb[1] = sif2.BOUT;
        end
        if (sif4.DONE && rk[2] < 0) begin
          rk[2] = k - 1; rd[2] = sif4.D; rb[2] = sif4.BOUT;
        end
        @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (rk[j] != want[j] || {rb[j], rd[j]} !== ex) begin
          n_bad++;
          $display("FAIL random_bpc%0d: X=%h Y=%h B0=%b got lat=%0d BOUT=%b D=%h want %0d/%b/%h",
                   1 << j, x, y, b, rk[j], rb[j], rd[j],
                   want[j], ex[8], ex[7:0]);
        end
      end
    end
  endtask

  initial begin
    sif1.START = 1'b0; sif1.X = '0; sif1.Y = '0; sif1.B0 = 1'b0;
    sif2.START = 1'b0; sif2.X = '0; sif2.Y = '0; sif2.B0 = 1'b0;
    sif4.START = 1'b0; sif4.X = '0; sif4.Y = '0; sif4.B0 = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_midshift_start();
    test_back_to_back();
    test_reset_midshift();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
